// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared types and 8b/10b K-code constants for the transmit sequencer
//
// Contents:
//   tx_seq_state_t : sequencer state encoding
//   K_IDLE/K_SOF/K_EOF/K_ERR/K_SKIP : control-symbol bytes (sent with kin=1)

package tx_pkg;

   // ST_SOF names the start-of-frame slot for readability in waves; the
   // sequencer emits SOF on the IDLE->DATA transition and never rests in it.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SOF   = 3'd1,
      ST_DATA  = 3'd2,
      ST_EOF   = 3'd3,
      ST_FLUSH = 3'd4,
      ST_IFG   = 3'd5
   } tx_seq_state_t;

   localparam logic [7:0] K_IDLE = 8'hBC;  // K28.5 comma
   localparam logic [7:0] K_SOF  = 8'hFB;  // K27.7
   localparam logic [7:0] K_EOF  = 8'hFD;  // K29.7
   localparam logic [7:0] K_ERR  = 8'hFE;  // K30.7
   localparam logic [7:0] K_SKIP = 8'h1C;  // K28.0

endpackage

// File: rtl/symbol_timer.sv
// rtl/symbol_timer.sv - symbol-rate divider producing one tick per SYM_CYCLES clocks
//
// Ports:
//   clk  in  : clock
//   rst  in  : asynchronous active-low reset
//   tick out : high for the one cycle where the symbol counter is SYM_CYCLES-1

module symbol_timer #(
   parameter int SYM_CYCLES = 10
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(SYM_CYCLES);

   logic [CW-1:0] sym_cnt;

   assign tick = (sym_cnt == CW'(SYM_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sym_cnt <= '0;
      end else if (tick) begin
         sym_cnt <= '0;
      end else begin
         sym_cnt <= sym_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/tx_frame_sequencer.sv
// rtl/tx_frame_sequencer.sv - frames upstream bytes into SOF/data/EOF symbols for the 8b/10b encoder
//
// Optional feature macro: TX_SKIP_EN (periodic SKIP insertion between frames).
//
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   s_valid/s_data/s_last : upstream byte stream; s_ready accepts a byte
//   enc_en/enc_kin/enc_din: one-cycle load strobe and symbol to the encoder
//   enc_kin_err           : encoder invalid-K flag
//   busy                  : a frame (SOF through end of IFG) is on the line
//   frame_done            : pulses with the EOF symbol
//   underrun, trunc       : sticky error flags
//   kin_err_cnt           : saturating count of enc_kin_err pulses

module tx_frame_sequencer
   import tx_pkg::*;
#(
   parameter int SYM_CYCLES = 10,
   parameter int MAX_LEN    = 256,
   parameter int MIN_IFG    = 2
`ifdef TX_SKIP_EN
   ,
   parameter int SKIP_INTERVAL = 1024
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       s_ready,
   output logic       enc_en,
   output logic       enc_kin,
   output logic [7:0] enc_din,
   input  logic       enc_kin_err,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun,
   output logic       trunc,
   output logic [7:0] kin_err_cnt
);

   localparam int BW = $clog2(MAX_LEN + 1);
   localparam int IW = $clog2(MIN_IFG + 1);

   logic tick;

   symbol_timer #(
      .SYM_CYCLES(SYM_CYCLES)
   ) u_symbol_timer (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   tx_seq_state_t state, state_d;
   logic [BW-1:0] byte_cnt, byte_cnt_d;
   logic [IW-1:0] ifg_cnt, ifg_cnt_d;
   logic          err_end, err_end_d;       // frame ended abnormally: drain via FLUSH
   logic          trunc_pend, trunc_pend_d; // raise trunc when the EOF goes out

   logic [7:0] sym_d;
   logic       kin_d;
   logic       done_d;
   logic       under_set;
   logic       trunc_set;
   logic [7:0] filler;                      // symbol for an idle slot (IDLE or SKIP)

`ifdef TX_SKIP_EN
   localparam int KW = $clog2(SKIP_INTERVAL + 1);

   logic [KW-1:0] idle_cnt;
   logic          idle_slot;
   logic          skip_due;

   // Only slots that would carry IDLE between frames advance the counter, so
   // a frame start simply defers a due SKIP to the next free slot.
   assign idle_slot = tick && ((state == ST_IDLE && !s_valid) || state == ST_IFG);
   assign skip_due  = (idle_cnt == KW'(SKIP_INTERVAL));
   assign filler    = skip_due ? K_SKIP : K_IDLE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
      end else if (idle_slot) begin
         idle_cnt <= skip_due ? '0 : idle_cnt + 1'b1;
      end
   end
`else
   assign filler = K_IDLE;
`endif

   // DATA accepts only on the tick; FLUSH drains as fast as the source offers.
   assign s_ready = (state == ST_FLUSH) || (state == ST_DATA && tick);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         ifg_cnt    <= '0;
         err_end    <= 1'b0;
         trunc_pend <= 1'b0;
      end else begin
         state      <= state_d;
         byte_cnt   <= byte_cnt_d;
         ifg_cnt    <= ifg_cnt_d;
         err_end    <= err_end_d;
         trunc_pend <= trunc_pend_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state;
      byte_cnt_d   = byte_cnt;
      ifg_cnt_d    = ifg_cnt;
      err_end_d    = err_end;
      trunc_pend_d = trunc_pend;
      case (state)
         ST_IDLE: begin
            if (tick && s_valid) begin
               state_d      = ST_DATA;
               byte_cnt_d   = '0;
               err_end_d    = 1'b0;
               trunc_pend_d = 1'b0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (s_valid) begin
                  byte_cnt_d = byte_cnt + 1'b1;
                  if (s_last) begin
                     // s_last wins over the length limit on the final byte
                     state_d = ST_EOF;
                  end else if (byte_cnt == BW'(MAX_LEN - 1)) begin
                     state_d      = ST_EOF;
                     err_end_d    = 1'b1;
                     trunc_pend_d = 1'b1;
                  end
               end else begin
                  state_d   = ST_EOF;
                  err_end_d = 1'b1;
               end
            end
         end
         ST_EOF: begin
            if (tick) begin
               state_d   = err_end ? ST_FLUSH : ST_IFG;
               ifg_cnt_d = '0;
            end
         end
         ST_FLUSH: begin
            if (s_valid && s_last) begin
               state_d   = ST_IFG;
               ifg_cnt_d = '0;
            end
         end
         ST_IFG: begin
            if (tick) begin
               if (ifg_cnt == IW'(MIN_IFG - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  ifg_cnt_d = ifg_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode: the symbol and flags that the next tick will load
   always_comb begin
      sym_d     = K_IDLE;
      kin_d     = 1'b1;
      done_d    = 1'b0;
      under_set = 1'b0;
      trunc_set = 1'b0;
      case (state)
         ST_IDLE: begin
            sym_d = s_valid ? K_SOF : filler;
         end
         ST_DATA: begin
            if (s_valid) begin
               sym_d = s_data;
               kin_d = 1'b0;
            end else begin
               sym_d     = K_ERR;
               under_set = 1'b1;
            end
         end
         ST_EOF: begin
            sym_d     = K_EOF;
            done_d    = 1'b1;
            trunc_set = trunc_pend;
         end
         ST_IFG: begin
            sym_d = filler;
         end
         default: begin
            sym_d = K_IDLE;
         end
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enc_en      <= 1'b0;
         enc_kin     <= 1'b1;
         enc_din     <= K_IDLE;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         underrun    <= 1'b0;
         trunc       <= 1'b0;
         kin_err_cnt <= '0;
      end else begin
         enc_en     <= tick;
         frame_done <= tick && done_d;
         if (tick) begin
            enc_din <= sym_d;
            enc_kin <= kin_d;
            // busy tracks whether the symbol now on the line belongs to a frame
            busy    <= (state != ST_IDLE) || s_valid;
            if (under_set) begin
               underrun <= 1'b1;
            end
            if (trunc_set) begin
               trunc <= 1'b1;
            end
         end
         if (enc_kin_err && kin_err_cnt != 8'hFF) begin
            kin_err_cnt <= kin_err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Symbol-rate controller for the 8b/10b transmit path: it sequences the encoder and serializer one symbol every `SYM_CYCLES` clocks. It frames upstream byte packets with control symbols (SOF/EOF), fills the line with comma idles between frames and enforces a minimum inter-frame gap. It also handles upstream underrun and oversize frames, and counts encoder `kin_err` reports. It sits between the packet source and the encoder input of the transmit top level.

## Interface
Parameters:
- `SYM_CYCLES`, 10: clocks per 10-bit symbol (serializer load period), ≥ 2
- `MAX_LEN`, 256: maximum payload bytes per frame, ≥ 1
- `MIN_IFG`, 2: minimum idle symbols between EOF and the next SOF, ≥ 1
- `SKIP_INTERVAL`, 1024: idle symbols between SKIP insertions (used only with `TX_SKIP_EN`)

Ports:
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-low reset
- `s_valid` in 1: upstream byte valid
- `s_data` in 8: upstream payload byte
- `s_last` in 1: last byte of frame
- `s_ready` out 1: byte accepted when `s_valid && s_ready`
- `enc_en` out 1: one-cycle pulse; encoder samples `enc_din`/`enc_kin`
- `enc_kin` out 1: control-symbol flag to encoder
- `enc_din` out 8: byte to encoder
- `enc_kin_err` in 1: encoder invalid-K flag, sampled the cycle after `enc_en`
- `busy` out 1: high from SOF emission through end of IFG
- `frame_done` out 1: one-cycle pulse when EOF is emitted
- `underrun` out 1: sticky; cleared by reset only
- `trunc` out 1: sticky; cleared by reset only
- `kin_err_cnt` out 8: saturating count of `enc_kin_err` pulses

## Operation
- Symbol codes: IDLE K28.5 = 8'hBC, SOF K27.7 = 8'hFB, EOF K29.7 = 8'hFD, ERR K30.7 = 8'hFE, SKIP K28.0 = 8'h1C; all emitted with `enc_kin`=1. Data is emitted with `enc_kin`=0.
- States: IDLE, SOF, DATA, EOF, FLUSH, IFG.
- IDLE: emits IDLE each tick. If `s_valid`=1 at a tick, the block emits SOF at that tick and moves to DATA; the byte is not consumed.
- DATA: `s_ready`=1 only during the tick cycle.
  - If `s_valid`=1, the block emits `s_data` and increments `byte_cnt`.
  - If `s_last`=1 is accepted, the next tick emits EOF.
  - If `s_valid`=0 at a tick (underrun), the block emits ERR, sets `underrun`, emits EOF at the next tick, then goes to FLUSH.
  - When `byte_cnt` reaches `MAX_LEN` without `s_last`, the next tick emits EOF, sets `trunc`, then goes to FLUSH.
- EOF: pulses `frame_done`, then goes to IFG. If the frame ended in error, it goes to FLUSH first.
- FLUSH: emits IDLE each tick; `s_ready`=1 every cycle; bytes are discarded until `s_last` is accepted, then the block goes to IFG.
- IFG: emits `MIN_IFG` IDLE symbols, then goes to IDLE. `s_ready`=0 throughout.
- `kin_err_cnt` increments on each `enc_kin_err`=1 and saturates at 8'hFF.

## Timing
- `sym_cnt` counts 0..`SYM_CYCLES`-1 and wraps; the tick is the cycle where `sym_cnt`==`SYM_CYCLES`-1.
- All outputs except `s_ready` are registered. `s_ready` is combinational from the state and `sym_cnt`.
- At the tick clock edge, `enc_din`/`enc_kin` load the next symbol. `enc_en`=1 for exactly the following cycle. Values hold until the next tick.
- First `enc_en` occurs `SYM_CYCLES` cycles after reset release.
- A byte accepted at a tick appears on `enc_din` one cycle later, with `enc_en`.
- Throughput: one byte per `SYM_CYCLES` cycles. Frame overhead is SOF + EOF + `MIN_IFG` symbols.
- Simultaneous `s_last` and `byte_cnt`==`MAX_LEN`-1: treated as a normal EOF; `trunc` is not set.
- Reset values: `enc_en`=0, `enc_kin`=1, `enc_din`=8'hBC, `s_ready`=0, `busy`=0, `frame_done`=0, `underrun`=0, `trunc`=0, `kin_err_cnt`=0, `sym_cnt`=0, state=IDLE.
- Reset assertion mid-frame aborts immediately; no EOF is emitted.

## Configuration
- `TX_SKIP_EN` defined: an idle-symbol counter runs in IDLE and IFG. When it reaches `SKIP_INTERVAL`, the next idle slot emits SKIP instead of IDLE and the counter clears. The counter holds, and does not reset, during SOF/DATA/EOF/FLUSH. A frame start takes priority over a pending SKIP, which is emitted at the next idle slot.
- `TX_SKIP_EN` undefined: no counter; only IDLE is emitted between frames.

## Structure
- Shared package `tx_pkg` holds:
  - the state enum `tx_seq_state_t`;
  - the K-code constants `K_IDLE`, `K_SOF`, `K_EOF`, `K_ERR`, `K_SKIP`.
- One sub-module, `symbol_timer`: generates `sym_cnt` and the tick.
- Everything else is in the sequencer.

## Test plan
- 3-byte frame AA/55/C3, `s_last` on C3, `s_valid` held → `enc_din` sequence BC, FB, AA, 55, C3, FD, BC, BC. `enc_kin` is 1,1,0,0,0,1,1,1. One `frame_done`. `enc_en` spacing is 10 cycles.
- Drop `s_valid` after the first byte of a 4-byte frame → FB, 11, FE, FD. `underrun`=1. Remaining bytes drained in FLUSH with `s_ready`=1. Next frame starts cleanly after the IFG.
- `MAX_LEN`=4, 6-byte frame → 4 data symbols then FD. `trunc`=1. Bytes 5–6 discarded. `frame_done` pulses once.
- Assert `rst` low while in DATA → all outputs return to reset values asynchronously. After release, the first `enc_en` is at cycle 10 with BC.
- `TX_SKIP_EN`, `SKIP_INTERVAL`=4, no traffic → pattern BC, BC, BC, BC, 1C repeating.
- Pulse `enc_kin_err` 300 times → `kin_err_cnt` saturates at FF.
